// File: rtl/mem_arb_defs.sv
// Shared definitions for the two-requester main-memory arbiter:
// FSM encodings, owner codes and default bus widths.
package mem_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_COOL = 2'd3
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

endpackage

// File: rtl/rr_pick2.sv
// Two-input grant picker: a lone requester always wins; on contention D wins
// when FIXED_D is set, otherwise the requester that was not served last.
module rr_pick2
  import mem_arb_defs::*;
#(
  parameter bit FIXED_D = 1'b0
) (
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = req_i | req_d;
    if (req_i && req_d) begin
      grant_owner = FIXED_D ? OWNER_D : ~last_grant;
    end else begin
      grant_owner = req_d ? OWNER_D : OWNER_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-wide memory port between the I-cache (read-only) and the
// D-cache (read/write), forwarding one whole transaction at a time.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FIXED_D = 0
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_mem_ready,
  output logic [DATA_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic              d_mem_ready,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state, state_next;
  logic   owner, last_grant;
  logic   req_i, req_d;
  logic   grant_valid, grant_owner;
  logic   take, finish;

  // The just-served requester is masked for one cycle after its ready pulse,
  // so its still-registered request cannot start a duplicate transaction.
  always_comb begin
    req_i = i_mem_read;
    req_d = d_mem_read | d_mem_write;
    if (state == ST_COOL) begin
      if (owner == OWNER_I) req_i = 1'b0;
      else                  req_d = 1'b0;
    end
  end

  rr_pick2 #(
    .FIXED_D (FIXED_D != 0)
  ) u_pick (
    .req_i       (req_i),
    .req_d       (req_d),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // NOTE: every output of a combinational block gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE, ST_COOL: begin
        if (grant_valid) begin
          take       = 1'b1;
          state_next = ST_BUSY;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          finish     = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_COOL;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state       <= ST_IDLE;
      owner       <= OWNER_I;
      last_grant  <= OWNER_I;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_mem_ready <= 1'b0;
      d_mem_ready <= 1'b0;
      i_mem_rdata <= '0;
      d_mem_rdata <= '0;
    end else begin
      state       <= state_next;
      i_mem_ready <= 1'b0;
      d_mem_ready <= 1'b0;
      if (take) begin
        owner <= grant_owner;
        if (grant_owner == OWNER_D) begin
          // A combined read+write from D forwards only the write.
          mem_addr  <= d_mem_addr;
          mem_wdata <= d_mem_wdata;
          mem_write <= d_mem_write;
          mem_read  <= ~d_mem_write;
        end else begin
          mem_addr  <= i_mem_addr;
          mem_wdata <= '0;
          mem_write <= 1'b0;
          mem_read  <= 1'b1;
        end
      end
      if (finish) begin
        mem_read   <= 1'b0;
        mem_write  <= 1'b0;
        last_grant <= owner;
        if (owner == OWNER_D) begin
          d_mem_rdata <= mem_rdata;
          d_mem_ready <= 1'b1;
        end else begin
          i_mem_rdata <= mem_rdata;
          i_mem_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance and a FIXED_D=1
// instance share requester stimulus, each with its own small memory model.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  localparam logic [DW-1:0] PAT_A5   = {16{8'hA5}};
  localparam logic [DW-1:0] PAT_I    = {4{32'h1111_0040}};
  localparam logic [DW-1:0] PAT_D    = {4{32'hDDDD_0050}};
  localparam logic [DW-1:0] PAT_W    = {8{16'h1234}};
  localparam logic [DW-1:0] PAT_CAFE = {4{32'hCAFE_F00D}};
  localparam logic [DW-1:0] PAT_5A   = {16{8'h5A}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          proc_reset;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_addr;
  logic          d_mem_read, d_mem_write;
  logic [AW-1:0] d_mem_addr;
  logic [DW-1:0] d_mem_wdata;

  logic          i_mem_ready, d_mem_ready, mem_read, mem_write;
  logic [DW-1:0] i_mem_rdata, d_mem_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;

  logic          fx_i_mem_ready, fx_d_mem_ready, fx_mem_read, fx_mem_write;
  logic [DW-1:0] fx_i_mem_rdata, fx_d_mem_rdata, fx_mem_wdata;
  logic [AW-1:0] fx_mem_addr;

  logic          mm_en, stray_ready;
  logic [DW-1:0] stray_rdata;
  logic          model_ready, fx_model_ready;
  logic [DW-1:0] model_rdata, fx_model_rdata;
  int            model_cnt, fx_model_cnt;
  logic [DW-1:0] store0 [256];
  logic [255:0]  valid0;

  int vectors = 0;
  int miscompares = 0;

  assign mem_ready = mm_en ? model_ready : stray_ready;
  assign mem_rdata = mm_en ? model_rdata : stray_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_D(0)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_ready(d_mem_ready), .d_mem_rdata(d_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_D(1)) fx (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_ready(fx_i_mem_ready), .i_mem_rdata(fx_i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_ready(fx_d_mem_ready), .d_mem_rdata(fx_d_mem_rdata),
    .mem_read(fx_mem_read), .mem_write(fx_mem_write),
    .mem_addr(fx_mem_addr), .mem_wdata(fx_mem_wdata),
    .mem_ready(fx_model_ready), .mem_rdata(fx_model_rdata)
  );

  // Contents of blocks never written by the bench.
  function automatic logic [DW-1:0] preset(input logic [AW-1:0] a);
    case (a)
      28'h0000010: preset = PAT_A5;
      28'h0000040: preset = PAT_I;
      28'h0000050: preset = PAT_D;
      default:     preset = {4{4'h0, a}};
    endcase
  endfunction

  // Memory model: mem_ready is seen by the arbiter at the third edge after the
  // grant edge, so mem_read/mem_write stay high for exactly three cycles.
  always @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      model_ready <= 1'b0;
      model_cnt   <= 0;
      model_rdata <= '0;
      valid0      <= '0;
    end else if (model_ready) begin
      model_ready <= 1'b0;
    end else if (mem_read || mem_write) begin
      if (model_cnt == 1) begin
        model_ready <= 1'b1;
        model_cnt   <= 0;
        if (mem_write) begin
          store0[mem_addr[7:0]] <= mem_wdata;
          valid0[mem_addr[7:0]] <= 1'b1;
          model_rdata           <= '0;
        end else begin
          model_rdata <= valid0[mem_addr[7:0]] ? store0[mem_addr[7:0]] : preset(mem_addr);
        end
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end
  end

  always @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      fx_model_ready <= 1'b0;
      fx_model_cnt   <= 0;
      fx_model_rdata <= '0;
    end else if (fx_model_ready) begin
      fx_model_ready <= 1'b0;
    end else if (fx_mem_read || fx_mem_write) begin
      if (fx_model_cnt == 1) begin
        fx_model_ready <= 1'b1;
        fx_model_cnt   <= 0;
        fx_model_rdata <= fx_mem_write ? '0 : preset(fx_mem_addr);
      end else begin
        fx_model_cnt <= fx_model_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic idle_inputs();
    i_mem_read  = 1'b0;
    i_mem_addr  = '0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_mem_addr  = '0;
    d_mem_wdata = '0;
    mm_en       = 1'b1;
    stray_ready = 1'b0;
    stray_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    proc_reset = 1'b1;
    ticks(2);
    proc_reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000 || mem_addr !== '0 ||
        mem_wdata !== '0 || i_mem_rdata !== '0 || d_mem_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: flags=%b addr=%h irdata=%h drdata=%h, want all zero",
               {mem_read, mem_write, i_mem_ready, d_mem_ready}, mem_addr, i_mem_rdata, d_mem_rdata);
    end
    i_mem_read = 1'b1;
    i_mem_addr = 28'h0000030;
    tick();
    vectors++;
    if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h0000030) begin
      miscompares++;
      $display("FAIL reset_pre_grant: rd/wr=%b addr=%h, want 10 0000030", {mem_read, mem_write}, mem_addr);
    end
    #2 proc_reset = 1'b1;
    #1;
    vectors++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000 || mem_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_async_clear: flags=%b addr=%h, want 0000 0000000",
               {mem_read, mem_write, i_mem_ready, d_mem_ready}, mem_addr);
    end
    i_mem_read = 1'b0;
    tick();
    proc_reset = 1'b0;
    tick();
    vectors++;
    if ({mem_read, mem_write} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_stays_idle: rd/wr=%b, want 00", {mem_read, mem_write});
    end
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h0000060;
    d_mem_wdata = PAT_5A;
    tick();
    vectors++;
    if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 28'h0000060) begin
      miscompares++;
      $display("FAIL reset_idle_grant: rd/wr=%b addr=%h, want 01 0000060", {mem_read, mem_write}, mem_addr);
    end
  endtask

  task automatic test_i_only();
    do_reset();
    i_mem_read = 1'b1;
    i_mem_addr = 28'h0000010;
    for (int c = 1; c <= 3; c++) begin
      tick();
      vectors++;
      if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b1000 || mem_addr !== 28'h0000010) begin
        miscompares++;
        $display("FAIL i_only_busy%0d: flags=%b addr=%h, want 1000 0000010",
                 c, {mem_read, mem_write, i_mem_ready, d_mem_ready}, mem_addr);
      end
    end
    tick();
    vectors++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0010 || i_mem_rdata !== PAT_A5) begin
      miscompares++;
      $display("FAIL i_only_ready: flags=%b rdata=%h, want 0010 %h",
               {mem_read, mem_write, i_mem_ready, d_mem_ready}, i_mem_rdata, PAT_A5);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000) begin
        miscompares++;
        $display("FAIL i_only_after%0d: flags=%b, want 0000 (pulse over, I masked)",
                 c, {mem_read, mem_write, i_mem_ready, d_mem_ready});
      end
    end
    i_mem_read = 1'b0;
    tick();
    vectors++;
    if (i_mem_rdata !== PAT_A5 || mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL i_only_hold: rdata=%h rd=%b, want %h 0", i_mem_rdata, mem_read, PAT_A5);
    end
  endtask

  task automatic test_contention_rr();
    do_reset();
    i_mem_read = 1'b1;
    i_mem_addr = 28'h0000040;
    d_mem_read = 1'b1;
    d_mem_addr = 28'h0000050;
    tick();
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000050) begin
      miscompares++;
      $display("FAIL rr_first_d: rd=%b addr=%h, want 1 0000050", mem_read, mem_addr);
    end
    ticks(3);
    vectors++;
    if ({i_mem_ready, d_mem_ready} !== 2'b01 || d_mem_rdata !== PAT_D) begin
      miscompares++;
      $display("FAIL rr_d_ready: i/d=%b rdata=%h, want 01 %h", {i_mem_ready, d_mem_ready}, d_mem_rdata, PAT_D);
    end
    d_mem_read = 1'b0;
    tick();
    vectors++;
    if ({mem_read, d_mem_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL rr_cool: rd/dready=%b, want 00", {mem_read, d_mem_ready});
    end
    tick();
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000040) begin
      miscompares++;
      $display("FAIL rr_i_from_cool: rd=%b addr=%h, want 1 0000040", mem_read, mem_addr);
    end
    ticks(3);
    vectors++;
    if ({i_mem_ready, d_mem_ready} !== 2'b10 || i_mem_rdata !== PAT_I) begin
      miscompares++;
      $display("FAIL rr_i_ready: i/d=%b rdata=%h, want 10 %h", {i_mem_ready, d_mem_ready}, i_mem_rdata, PAT_I);
    end
    i_mem_read = 1'b0;
    ticks(2);
    d_mem_read = 1'b1;
    ticks(4);
    vectors++;
    if (d_mem_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rr_d_alone: dready=%b, want 1", d_mem_ready);
    end
    d_mem_read = 1'b0;
    ticks(2);
    i_mem_read = 1'b1;
    d_mem_read = 1'b1;
    tick();
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000040) begin
      miscompares++;
      $display("FAIL rr_alt_i: rd=%b addr=%h, want 1 0000040", mem_read, mem_addr);
    end
    ticks(3);
    vectors++;
    if ({i_mem_ready, d_mem_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rr_alt_i_ready: i/d=%b, want 10", {i_mem_ready, d_mem_ready});
    end
    ticks(2);
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000050) begin
      miscompares++;
      $display("FAIL rr_alt_d: rd=%b addr=%h, want 1 0000050", mem_read, mem_addr);
    end
  endtask

  task automatic test_fixed_d();
    do_reset();
    d_mem_read = 1'b1;
    d_mem_addr = 28'h0000050;
    ticks(4);
    vectors++;
    if ({fx_d_mem_ready, d_mem_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL fx_prime: fx_d/d ready=%b, want 11", {fx_d_mem_ready, d_mem_ready});
    end
    d_mem_read = 1'b0;
    ticks(2);
    i_mem_read = 1'b1;
    i_mem_addr = 28'h0000040;
    d_mem_read = 1'b1;
    tick();
    vectors++;
    if (fx_mem_read !== 1'b1 || fx_mem_addr !== 28'h0000050 || mem_addr !== 28'h0000040) begin
      miscompares++;
      $display("FAIL fx_d_wins: fx rd=%b fx addr=%h rr addr=%h, want 1 0000050 0000040",
               fx_mem_read, fx_mem_addr, mem_addr);
    end
    ticks(3);
    vectors++;
    if ({fx_i_mem_ready, fx_d_mem_ready} !== 2'b01 || fx_d_mem_rdata !== PAT_D) begin
      miscompares++;
      $display("FAIL fx_d_ready: i/d=%b rdata=%h, want 01 %h", {fx_i_mem_ready, fx_d_mem_ready}, fx_d_mem_rdata, PAT_D);
    end
    ticks(2);
    vectors++;
    if (fx_mem_read !== 1'b1 || fx_mem_addr !== 28'h0000040) begin
      miscompares++;
      $display("FAIL fx_i_when_d_masked: rd=%b addr=%h, want 1 0000040", fx_mem_read, fx_mem_addr);
    end
    ticks(3);
    vectors++;
    if ({fx_i_mem_ready, fx_d_mem_ready} !== 2'b10 || fx_i_mem_rdata !== PAT_I) begin
      miscompares++;
      $display("FAIL fx_i_ready: i/d=%b rdata=%h, want 10 %h", {fx_i_mem_ready, fx_d_mem_ready}, fx_i_mem_rdata, PAT_I);
    end
    ticks(2);
    vectors++;
    if (fx_mem_read !== 1'b1 || fx_mem_addr !== 28'h0000050) begin
      miscompares++;
      $display("FAIL fx_d_again: rd=%b addr=%h, want 1 0000050", fx_mem_read, fx_mem_addr);
    end
  endtask

  task automatic test_d_read_write();
    do_reset();
    d_mem_read  = 1'b1;
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h0000020;
    d_mem_wdata = PAT_W;
    tick();
    vectors++;
    if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 28'h0000020 || mem_wdata !== PAT_W) begin
      miscompares++;
      $display("FAIL rw_write_only: rd/wr=%b addr=%h wdata=%h, want 01 0000020 %h",
               {mem_read, mem_write}, mem_addr, mem_wdata, PAT_W);
    end
    ticks(3);
    vectors++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL rw_ready: flags=%b, want 0001", {mem_read, mem_write, i_mem_ready, d_mem_ready});
    end
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    tick();
    vectors++;
    if (d_mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_one_pulse: dready=%b, want 0", d_mem_ready);
    end
    tick();
    d_mem_read = 1'b1;
    tick();
    vectors++;
    if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h0000020) begin
      miscompares++;
      $display("FAIL rw_reread: rd/wr=%b addr=%h, want 10 0000020", {mem_read, mem_write}, mem_addr);
    end
    ticks(3);
    vectors++;
    if (d_mem_ready !== 1'b1 || d_mem_rdata !== PAT_W) begin
      miscompares++;
      $display("FAIL rw_readback: dready=%b rdata=%h, want 1 %h", d_mem_ready, d_mem_rdata, PAT_W);
    end
  endtask

  task automatic test_stray_ready();
    do_reset();
    mm_en       = 1'b0;
    stray_ready = 1'b1;
    stray_rdata = PAT_5A;
    ticks(2);
    vectors++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000 ||
        i_mem_rdata !== '0 || d_mem_rdata !== '0) begin
      miscompares++;
      $display("FAIL stray_idle: flags=%b irdata=%h drdata=%h, want 0000 0 0",
               {mem_read, mem_write, i_mem_ready, d_mem_ready}, i_mem_rdata, d_mem_rdata);
    end
    stray_ready = 1'b0;
    i_mem_read  = 1'b1;
    i_mem_addr  = 28'h0000070;
    tick();
    stray_ready = 1'b1;
    stray_rdata = PAT_CAFE;
    tick();
    vectors++;
    if ({i_mem_ready, d_mem_ready} !== 2'b10 || i_mem_rdata !== PAT_CAFE) begin
      miscompares++;
      $display("FAIL stray_busy_done: i/d=%b rdata=%h, want 10 %h", {i_mem_ready, d_mem_ready}, i_mem_rdata, PAT_CAFE);
    end
    i_mem_read  = 1'b0;
    stray_rdata = PAT_5A;
    ticks(2);
    vectors++;
    if ({mem_read, i_mem_ready, d_mem_ready} !== 3'b000 || i_mem_rdata !== PAT_CAFE || d_mem_rdata !== '0) begin
      miscompares++;
      $display("FAIL stray_cool: flags=%b irdata=%h drdata=%h, want 000 %h 0",
               {mem_read, i_mem_ready, d_mem_ready}, i_mem_rdata, d_mem_rdata, PAT_CAFE);
    end
    stray_ready = 1'b0;
    d_mem_read  = 1'b1;
    d_mem_addr  = 28'h0000080;
    tick();
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000080) begin
      miscompares++;
      $display("FAIL stray_state_idle: rd=%b addr=%h, want 1 0000080", mem_read, mem_addr);
    end
  endtask

  initial begin
    proc_reset = 1'b1;
    idle_inputs();
    test_reset();
    test_i_only();
    test_contention_rr();
    test_fixed_d();
    test_d_read_write();
    test_stray_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
